// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and default word width.
package serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      PAR   = 2'b10
   } state_t;

endpackage

// File: rtl/bit_counter_wrap.sv
// Wrapping bit counter 0..WIDTH-1 with clear/enable; tc flags the last bit position.
module bit_counter_wrap
   import serializer_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   assign tc = (cnt == CNT_W'(WIDTH - 1));

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with valid/ready input and gap-free back-to-back words.
// Optional even-parity trailer bit enabled by defining SERIALIZER_PARITY_EN.
module bit_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             word_done
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic               x_d, x_valid_d, word_done_d;
   logic               cnt_clr, cnt_en, tc, accept;
   logic [CNT_W-1:0]   cnt;

`ifdef SERIALIZER_PARITY_EN
   logic par_q, par_d;
`endif

   bit_counter_wrap #(.WIDTH(WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .tc  (tc)
   );

   // Ready in IDLE and during the final bit of the word, so the next word follows with no gap.
   always_comb begin
`ifdef SERIALIZER_PARITY_EN
      din_ready = (state_q == IDLE) || (state_q == PAR);
`else
      din_ready = (state_q == IDLE) || ((state_q == SHIFT) && tc);
`endif
   end

   assign accept = din_valid && din_ready;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      x_d         = 1'b0;
      x_valid_d   = 1'b0;
      word_done_d = 1'b0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_d       = par_q;
`endif
      if (accept) begin
         state_d   = SHIFT;
         x_d       = din[WIDTH-1];
         x_valid_d = 1'b1;
         sreg_d    = {din[WIDTH-2:0], 1'b0};
         cnt_clr   = 1'b1;
`ifdef SERIALIZER_PARITY_EN
         par_d     = ^din;
`endif
      end else begin
         case (state_q)
            SHIFT: begin
               if (!tc) begin
                  x_d       = sreg_q[WIDTH-1];
                  x_valid_d = 1'b1;
                  sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
                  cnt_en    = 1'b1;
`ifndef SERIALIZER_PARITY_EN
                  word_done_d = (cnt == CNT_W'(WIDTH - 2));
`endif
               end else begin
`ifdef SERIALIZER_PARITY_EN
                  state_d     = PAR;
                  x_d         = par_q;
                  x_valid_d   = 1'b1;
                  word_done_d = 1'b1;
`else
                  state_d     = IDLE;
                  cnt_clr     = 1'b1;
`endif
               end
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // Synchronous reset discards any word in flight; word_done is never raised for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         x         <= 1'b0;
         x_valid   <= 1'b0;
         word_done <= 1'b0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         x         <= x_d;
         x_valid   <= x_valid_d;
         word_done <= word_done_d;
      end
   end

`ifdef SERIALIZER_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end
`endif

endmodule
